bcd_multi_counter: RTL and testbench

Synchronous multi-digit BCD up/down counter for the score, distance and timer displays. It generalises the single-digit decade counter to DIGITS cascaded decades inside one clock domain. It adds up/down stepping, parallel load, synchronous clear and wrap or saturate modes. Outputs drive the seven-segment/HUD digit mux directly.

---
 rtl/bcd_multi_counter.sv | 139 +++++++++++++
 tb/tb_bcd_multi_counter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bcd_multi_counter.sv
// Multi-digit BCD up/down counter with load, clear and wrap/saturate modes.
// Optional leading-zero blank mask enabled by BCD_MULTI_COUNTER_LZB_EN.
module bcd_multi_counter #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic                inc,
    input  logic                dec,
    output logic [4*DIGITS-1:0] value,
    output logic                carry_out,
    output logic                borrow_out,
    output logic                at_max,
    output logic                at_zero,
    output logic                ovf,
    output logic [DIGITS-1:0]   blank
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic [W-1:0] up_val;
    logic [W-1:0] dn_val;
    logic [W-1:0] ld_val;
    logic         up_wrap;
    logic         dn_wrap;
    logic         carry_q;
    logic         carry_d;
    logic         borrow_q;
    logic         borrow_d;
    logic         ovf_q;
    logic         ovf_d;

    // Full ripple through all decades; a surviving carry/borrow means wrap.
    always_comb begin : step_logic
        logic       cu;
        logic       bd;
        logic [3:0] d;
        up_val = '0;
        dn_val = '0;
        ld_val = '0;
        cu     = 1'b1;
        bd     = 1'b1;
        d      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = value_q[4*i +: 4];
            if (cu && d == 4'd9) begin
                up_val[4*i +: 4] = 4'd0;
            end else if (cu) begin
                up_val[4*i +: 4] = d + 4'd1;
                cu = 1'b0;
            end else begin
                up_val[4*i +: 4] = d;
            end
            if (bd && d == 4'd0) begin
                dn_val[4*i +: 4] = 4'd9;
            end else if (bd) begin
                dn_val[4*i +: 4] = d - 4'd1;
                bd = 1'b0;
            end else begin
                dn_val[4*i +: 4] = d;
            end
            d = load_value[4*i +: 4];
            ld_val[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
        end
        up_wrap = cu;
        dn_wrap = bd;
    end

    always_comb begin : next_state
        value_d  = value_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        ovf_d    = ovf_q;
        if (clr) begin
            value_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            value_d = ld_val;
            ovf_d   = 1'b0;
        end else if (inc && !dec) begin
            if (up_wrap && SATURATE) begin
                ovf_d = 1'b1;
            end else begin
                value_d = up_val;
                carry_d = up_wrap;
            end
        end else if (dec && !inc) begin
            if (dn_wrap && SATURATE) begin
                ovf_d = 1'b1;
            end else begin
                value_d  = dn_val;
                borrow_d = dn_wrap;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            value_q  <= value_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign value      = value_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign ovf        = SATURATE ? ovf_q : 1'b0;
    assign at_max     = up_wrap;
    assign at_zero    = dn_wrap;

`ifdef BCD_MULTI_COUNTER_LZB_EN
    // Digit 0 is never blanked so a zero count still shows one "0".
    always_comb begin : lzb
        logic hz;
        hz    = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hz       = hz && (value_q[4*i +: 4] == 4'd0);
            blank[i] = hz;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Directed table-driven bench for bcd_multi_counter, wrap and saturate builds.
module tb_bcd_multi_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        load;
    logic [15:0] load_value;
    logic        inc;
    logic        dec;

    logic [15:0] value0, value1;
    logic        carry0, carry1;
    logic        borrow0, borrow1;
    logic        max0, max1;
    logic        zero0, zero1;
    logic        ovf0, ovf1;
    logic [3:0]  blank0, blank1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    bcd_multi_counter #(.DIGITS(4), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .clr(clr), .load(load),
        .load_value(load_value), .inc(inc), .dec(dec),
        .value(value0), .carry_out(carry0), .borrow_out(borrow0),
        .at_max(max0), .at_zero(zero0), .ovf(ovf0), .blank(blank0)
    );

    bcd_multi_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .clr(clr), .load(load),
        .load_value(load_value), .inc(inc), .dec(dec),
        .value(value1), .carry_out(carry1), .borrow_out(borrow1),
        .at_max(max1), .at_zero(zero1), .ovf(ovf1), .blank(blank1)
    );

    typedef struct {
        logic        clr;
        logic        load;
        logic [15:0] lv;
        logic        inc;
        logic        dec;
        logic [15:0] ev;
        logic        ec;
        logic        eb;
        logic [3:0]  ebl;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_blank(input logic [3:0] lzb);
`ifdef BCD_MULTI_COUNTER_LZB_EN
        return lzb;
`else
        return 4'b0000 & lzb;
`endif
    endfunction

    // Apply inputs away from the edge, clock once, settle.
    task automatic step(input logic c, input logic l, input logic [15:0] lv,
                        input logic i, input logic d);
        clr = c; load = l; load_value = lv; inc = i; dec = d;
        @(posedge clk);
        #1;
        clr = 0; load = 0; inc = 0; dec = 0;
    endtask

    function automatic vec_t mk(input logic c, input logic l,
                                input logic [15:0] lv, input logic i,
                                input logic d, input logic [15:0] ev,
                                input logic ec, input logic eb,
                                input logic [3:0] ebl);
        vec_t v;
        v.clr = c; v.load = l; v.lv = lv; v.inc = i; v.dec = d;
        v.ev = ev; v.ec = ec; v.eb = eb; v.ebl = ebl;
        return v;
    endfunction

    initial begin
        // count 1..9 then 10
        for (int k = 1; k <= 9; k++)
            tv.push_back(mk(0, 0, 0, 1, 0, 16'(k), 0, 0, 4'b1110));
        tv.push_back(mk(0, 0, 0, 1, 0, 16'h0010, 0, 0, 4'b1100));
        tv.push_back(mk(0, 0, 0, 0, 0, 16'h0010, 0, 0, 4'b1100));
        tv.push_back(mk(0, 1, 16'h9998, 0, 0, 16'h9998, 0, 0, 4'b0000));
        tv.push_back(mk(0, 0, 0, 1, 0, 16'h9999, 0, 0, 4'b0000));
        tv.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 1, 0, 4'b1110));
        tv.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 4'b1110));
        tv.push_back(mk(0, 0, 0, 0, 1, 16'h9999, 0, 1, 4'b0000));
        tv.push_back(mk(0, 0, 0, 0, 0, 16'h9999, 0, 0, 4'b0000));
        tv.push_back(mk(0, 1, 16'h0123, 0, 0, 16'h0123, 0, 0, 4'b1000));
        for (int k = 0; k < 3; k++)
            tv.push_back(mk(0, 0, 0, 1, 1, 16'h0123, 0, 0, 4'b1000));
        tv.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 0, 0, 4'b1110));
        tv.push_back(mk(0, 1, 16'h0A5F, 0, 0, 16'h0959, 0, 0, 4'b1000));
        tv.push_back(mk(0, 0, 0, 0, 1, 16'h0958, 0, 0, 4'b1000));
        tv.push_back(mk(0, 1, 16'h0199, 0, 0, 16'h0199, 0, 0, 4'b1000));
        tv.push_back(mk(0, 0, 0, 1, 0, 16'h0200, 0, 0, 4'b1000));
        tv.push_back(mk(0, 0, 0, 0, 1, 16'h0199, 0, 0, 4'b1000));
        tv.push_back(mk(0, 1, 16'h1000, 0, 0, 16'h1000, 0, 0, 4'b0000));
        tv.push_back(mk(0, 0, 0, 0, 1, 16'h0999, 0, 0, 4'b1000));
        tv.push_back(mk(0, 1, 16'hFFFF, 1, 0, 16'h9999, 0, 0, 4'b0000));
        tv.push_back(mk(0, 1, 16'h0040, 0, 0, 16'h0040, 0, 0, 4'b1100));

        reset = 1; clr = 0; load = 0; load_value = 0; inc = 0; dec = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_value", value0, 16'h0000);
        chk("rst_carry", carry0, 1'b0);
        chk("rst_borrow", borrow0, 1'b0);
        chk("rst_ovf", ovf1, 1'b0);
        chk("rst_zero", zero0, 1'b1);
        chk("rst_blank", blank0, exp_blank(4'b1110));
        reset = 0;

        foreach (tv[n]) begin
            step(tv[n].clr, tv[n].load, tv[n].lv, tv[n].inc, tv[n].dec);
            chk($sformatf("v%0d_value", n), value0, tv[n].ev);
            chk($sformatf("v%0d_carry", n), carry0, tv[n].ec);
            chk($sformatf("v%0d_borrow", n), borrow0, tv[n].eb);
            chk($sformatf("v%0d_max", n), max0, tv[n].ev == 16'h9999);
            chk($sformatf("v%0d_zero", n), zero0, tv[n].ev == 16'h0000);
            chk($sformatf("v%0d_blank", n), blank0, exp_blank(tv[n].ebl));
            chk($sformatf("v%0d_ovf0", n), ovf0, 1'b0);
        end

        // Saturating underflow/overflow versus wrapping twin.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("sat_dn_value", value1, 16'h0000);
        chk("sat_dn_ovf", ovf1, 1'b1);
        chk("sat_dn_borrow", borrow1, 1'b0);
        chk("wrap_dn_value", value0, 16'h9999);
        chk("wrap_dn_borrow", borrow0, 1'b1);
        step(0, 0, 0, 1, 0);
        chk("sat_sticky_value", value1, 16'h0001);
        chk("sat_sticky_ovf", ovf1, 1'b1);
        step(0, 1, 16'h9999, 0, 0);
        chk("sat_load_ovf", ovf1, 1'b0);
        step(0, 0, 0, 1, 0);
        chk("sat_up_value", value1, 16'h9999);
        chk("sat_up_ovf", ovf1, 1'b1);
        chk("sat_up_carry", carry1, 1'b0);
        chk("sat_up_max", max1, 1'b1);
        step(1, 0, 0, 1, 0);
        chk("sat_clr_ovf", ovf1, 1'b0);
        chk("sat_clr_value", value1, 16'h0000);

        // Asynchronous reset between strobes.
        step(0, 1, 16'h0959, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("pre_areset", value0, 16'h0960);
        #2 reset = 1;
        #1;
        chk("areset_value0", value0, 16'h0000);
        chk("areset_value1", value1, 16'h0000);
        #1 reset = 0;
        step(0, 0, 0, 1, 0);
        chk("post_areset", value0, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
